// File: rtl/branch_predictor.sv
// BTB-based direction/target predictor with 2-bit counters, plus the
// Execute-stage misprediction check that drives redirect, flushes and statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        predTakenF,
    output logic [31:0] predTargetF,
    input  logic        validE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [2:0]  branchE,
    input  logic [1:0]  jumpE,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] actualTargetE,
    input  logic        predTakenE,
    input  logic [31:0] predTargetE,
    output logic        redirectE,
    output logic [31:0] redirectPCE,
    output logic        flushD,
    output logic        flushE,
    output logic [15:0] branchCount,
    output logic [15:0] mispredictCount
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX - 2;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [15:0]      branch_cnt_q, branch_cnt_d;
    logic [15:0]      misp_cnt_q, misp_cnt_d;

    logic [IDX-1:0]   f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             cf_e, taken_e, misp_e;
    logic             unused_pce_low;

    assign unused_pce_low = ^PCE[1:0];

    // Fetch-side lookup sees the registered (pre-update) BTB contents.
    assign f_idx       = PCF[IDX+1:2];
    assign f_tag       = PCF[31:IDX+2];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign predTakenF  = f_hit && ctr_q[f_idx][1];
    assign predTargetF = predTakenF ? target_q[f_idx] : PCF + 32'd4;

    assign e_idx   = PCE[IDX+1:2];
    assign e_tag   = PCE[31:IDX+2];
    assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign cf_e    = validE && ((branchE != 3'd0) || (jumpE != 2'd0));
    assign taken_e = (PCSrcE != 2'b00);
    assign misp_e  = validE && ((taken_e != predTakenE) ||
                                (taken_e && (predTargetE != actualTargetE)));

    assign redirectE       = misp_e;
    assign flushD          = misp_e;
    assign flushE          = misp_e;
    assign redirectPCE     = taken_e ? actualTargetE : PCPlus4E;
    assign branchCount     = branch_cnt_q;
    assign mispredictCount = misp_cnt_q;

    // BTB and statistics next-state.
    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        target_d     = target_q;
        ctr_d        = ctr_q;
        branch_cnt_d = branch_cnt_q;
        misp_cnt_d   = misp_cnt_q;
        if (cf_e) begin
            if (e_hit) begin
                if (taken_e) begin
                    ctr_d[e_idx]    = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
                    target_d[e_idx] = actualTargetE;
                end else begin
                    ctr_d[e_idx]    = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
                end
            end else if (taken_e) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = actualTargetE;
                ctr_d[e_idx]    = 2'b10;
            end
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_d = branch_cnt_q + 16'd1;
            end
        end
        if (misp_e && (misp_cnt_q != CNT_MAX)) begin
            misp_cnt_d = misp_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        validE;
    logic [31:0] PCE, PCPlus4E;
    logic [2:0]  branchE;
    logic [1:0]  jumpE, PCSrcE;
    logic [31:0] actualTargetE;
    logic        predTakenE;
    logic [31:0] predTargetE;
    logic        redirectE;
    logic [31:0] redirectPCE;
    logic        flushD, flushE;
    logic [15:0] branchCount, mispredictCount;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF),
        .predTakenF(predTakenF), .predTargetF(predTargetF),
        .validE(validE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .branchE(branchE), .jumpE(jumpE), .PCSrcE(PCSrcE),
        .actualTargetE(actualTargetE), .predTakenE(predTakenE),
        .predTargetE(predTargetE), .redirectE(redirectE),
        .redirectPCE(redirectPCE), .flushD(flushD), .flushE(flushE),
        .branchCount(branchCount), .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_e(input logic [31:0] pc, input logic [2:0] br, input logic [1:0] jp,
                           input logic [1:0] src, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
        validE        = 1'b1;
        PCE           = pc;
        PCPlus4E      = pc + 32'd4;
        branchE       = br;
        jumpE         = jp;
        PCSrcE        = src;
        actualTargetE = tgt;
        predTakenE    = pt;
        predTargetE   = ptgt;
    endtask

    task automatic idle_e();
        validE        = 1'b0;
        PCE           = 32'h0;
        PCPlus4E      = 32'h4;
        branchE       = 3'd0;
        jumpE         = 2'd0;
        PCSrcE        = 2'd0;
        actualTargetE = 32'h0;
        predTakenE    = 1'b0;
        predTargetE   = 32'h0;
    endtask

    // Advance one edge, retire the Execute slot and settle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_e();
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] pc,
                               input logic exp_taken, input logic [31:0] exp_tgt);
        PCF = pc;
        #1;
        check_eq({tag, "_taken"}, 32'(predTakenF), 32'(exp_taken));
        check_eq({tag, "_target"}, predTargetF, exp_tgt);
    endtask

    task automatic check_counts(input string tag, input int br, input int mp);
        check_eq({tag, "_branchCount"}, 32'(branchCount), 32'(br));
        check_eq({tag, "_mispCount"}, 32'(mispredictCount), 32'(mp));
    endtask

    task automatic check_redirect(input string tag, input logic exp_r, input logic [31:0] exp_pc);
        check_eq({tag, "_redirect"}, 32'(redirectE), 32'(exp_r));
        check_eq({tag, "_flushD"}, 32'(flushD), 32'(exp_r));
        check_eq({tag, "_flushE"}, 32'(flushE), 32'(exp_r));
        check_eq({tag, "_redirectPC"}, redirectPCE, exp_pc);
    endtask

    initial begin
        rst_n = 1'b0;
        PCF   = 32'h40;
        idle_e();
        PCPlus4E = 32'h1234;
        #2;
        check_fetch("rst", 32'h40, 1'b0, 32'h44);
        check_redirect("rst", 1'b0, 32'h1234);
        check_counts("rst", 0, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First BEQ at 0x40 misses and is taken: allocate with ctr=10.
        drive_e(32'h40, 3'd1, 2'd0, 2'b01, 32'h80, 1'b0, 32'h44);
        #1;
        check_redirect("beq_miss", 1'b1, 32'h80);
        tick();
        check_counts("beq_miss", 1, 1);
        check_fetch("alloc", 32'h40, 1'b1, 32'h80);

        // Not taken once: ctr 10->01; fetch in the same cycle still sees old entry.
        drive_e(32'h40, 3'd1, 2'd0, 2'b00, 32'h80, 1'b1, 32'h80);
        check_fetch("rbw", 32'h40, 1'b1, 32'h80);
        check_redirect("nt1", 1'b1, 32'h44);
        tick();
        check_fetch("ctr01", 32'h40, 1'b0, 32'h44);
        check_counts("nt1", 2, 2);

        // Taken (mispredicted) ctr 01->10, then correct taken 10->11.
        drive_e(32'h40, 3'd1, 2'd0, 2'b01, 32'h80, 1'b0, 32'h44);
        #1;
        check_redirect("tk1", 1'b1, 32'h80);
        tick();
        check_fetch("ctr10", 32'h40, 1'b1, 32'h80);
        drive_e(32'h40, 3'd1, 2'd0, 2'b01, 32'h80, 1'b1, 32'h80);
        #1;
        check_redirect("correct", 1'b0, 32'h80);
        tick();
        check_counts("correct", 4, 3);

        // One not-taken from 11 leaves 10: still predicts taken.
        drive_e(32'h40, 3'd1, 2'd0, 2'b00, 32'h80, 1'b1, 32'h80);
        tick();
        check_fetch("hyst", 32'h40, 1'b1, 32'h80);
        check_counts("hyst", 5, 4);

        // JALR at 0x100 (same index as 0x40): allocate target 0x200.
        drive_e(32'h100, 3'd0, 2'b10, 2'b10, 32'h200, 1'b0, 32'h104);
        tick();
        check_fetch("jalr_alloc", 32'h100, 1'b1, 32'h200);
        check_fetch("jalr_evict", 32'h40, 1'b0, 32'h44);
        drive_e(32'h100, 3'd0, 2'b10, 2'b10, 32'h300, 1'b1, 32'h200);
        #1;
        check_redirect("jalr_tgt", 1'b1, 32'h300);
        tick();
        check_fetch("jalr_new", 32'h100, 1'b1, 32'h300);
        check_counts("jalr", 7, 6);

        // Alias: taken BEQ at 0x80 overwrites index 0.
        drive_e(32'h80, 3'd1, 2'd0, 2'b01, 32'hC0, 1'b0, 32'h84);
        tick();
        check_fetch("alias_40", 32'h40, 1'b0, 32'h44);
        check_fetch("alias_100", 32'h100, 1'b0, 32'h104);
        check_fetch("alias_80", 32'h80, 1'b1, 32'hC0);

        // Bubble with predicted-taken garbage: nothing happens.
        drive_e(32'h80, 3'd1, 2'd0, 2'b01, 32'h500, 1'b1, 32'hC0);
        validE = 1'b0;
        PCSrcE = 2'b00;
        #1;
        check_redirect("bubble", 1'b0, 32'h84);
        tick();
        check_counts("bubble", 8, 7);
        check_fetch("bubble_btb", 32'h80, 1'b1, 32'hC0);

        // Non-control instruction predicted taken: redirect to PC+4, no BTB change.
        drive_e(32'h200, 3'd0, 2'd0, 2'b00, 32'h0, 1'b1, 32'h999);
        #1;
        check_redirect("nonctl", 1'b1, 32'h204);
        tick();
        check_counts("nonctl", 8, 8);
        check_fetch("nonctl_btb", 32'h200, 1'b0, 32'h204);

        // Not-taken miss at 0x44 (index 1): counted, no allocation.
        drive_e(32'h44, 3'd2, 2'd0, 2'b00, 32'h10, 1'b0, 32'h48);
        #1;
        check_redirect("nt_miss", 1'b0, 32'h48);
        tick();
        check_counts("nt_miss", 9, 8);
        check_fetch("nt_miss_btb", 32'h44, 1'b0, 32'h48);

        // Asynchronous reset between edges.
        check_fetch("pre_rst", 32'h80, 1'b1, 32'hC0);
        rst_n = 1'b0;
        #1;
        check_fetch("async_rst", 32'h80, 1'b0, 32'h84);
        check_counts("async_rst", 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_fetch("post_rst", 32'h80, 1'b0, 32'h84);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and misprediction-recovery controller for the 5-stage RISC-V pipeline. It predicts direction and target for the fetch-stage PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. When the control-flow instruction reaches Execute, it compares the prediction against the resolved `PCSrcE` from the branch controller. It then issues the PC redirect and the Decode/Execute flushes, and updates the BTB and its statistics counters.

## Interface
- `ENTRIES`, 16: BTB entry count; power of two, 4..256. `IDX = log2(ENTRIES)`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCF` in 32: fetch-stage PC.
- `predTakenF` out 1: prediction for `PCF` is taken.
- `predTargetF` out 32: predicted next PC when taken. Equals `PCF+4` otherwise.
- `validE` in 1: Execute holds a real instruction (0 on bubble or flush).
- `PCE` in 32: Execute-stage PC.
- `PCPlus4E` in 32: `PCE+4`.
- `branchE` in 3: branch type (000 none/jump, 001 BEQ, 010 BNE, 011 BLT, 100 BGE).
- `jumpE` in 2: 01 JAL, 10 JALR, 00 none.
- `PCSrcE` in 2: resolved source from the branch controller (00 sequential, 01 PC-relative taken, 10 JALR taken).
- `actualTargetE` in 32: resolved taken target. Selected upstream by `PCSrcE`.
- `predTakenE` in 1: `predTakenF` carried down the pipeline with the instruction.
- `predTargetE` in 32: `predTargetF` carried down the pipeline with the instruction.
- `redirectE` out 1: fetch must load `redirectPCE` at the next edge.
- `redirectPCE` out 32: corrected next PC.
- `flushD` out 1: flush the Decode register.
- `flushE` out 1: flush the Execute register.
- `branchCount` out 16: resolved control-flow instructions.
- `mispredictCount` out 16: mispredictions.

## Operation
- **Entry format:** `valid`, `tag = PC[31:IDX+2]`, `target[31:0]`, `ctr[1:0]`.
- **Fetch index:** `PCF[IDX+1:2]`.
- **Fetch prediction (combinational):**
  - Hit means `valid` is set and `tag` matches.
  - `predTakenF = hit & ctr[1]`.
  - `predTargetF = predTakenF ? target : PCF+4`.
- **Control flow in Execute:** `cfE = validE & (branchE != 0 | jumpE != 0)`.
- **Actual direction:** `takenE = (PCSrcE != 00)`.
- **Misprediction:** `mispE = validE & ((takenE != predTakenE) | (takenE & predTargetE != actualTargetE))`.
  - This also covers a non-control instruction that was predicted taken; it is redirected to `PCPlus4E`.
- **Recovery:**
  - `redirectE = flushD = flushE = mispE`.
  - `redirectPCE = takenE ? actualTargetE : PCPlus4E`.
- **BTB update (clocked, when `cfE`), index `PCE[IDX+1:2]`:**
  - Hit, taken: `ctr` saturating +1 (max 11); `target <= actualTargetE`.
  - Hit, not taken: `ctr` saturating −1 (min 00); `target` unchanged.
  - Miss, taken: allocate (overwrite): `valid = 1`, `tag`, `target = actualTargetE`, `ctr = 10`.
  - Miss, not taken: no change.
  - JAL/JALR follow the taken rules, so their counters saturate at 11.
- **Statistics:**
  - `branchCount` increments on every `cfE`.
  - `mispredictCount` increments on every `mispE`.
  - Both saturate at 16'hFFFF and never wrap.

## Timing
- **Fetch prediction:** zero latency, combinational from `PCF` and BTB state.
- **Redirect and flush:** combinational in the same cycle the instruction is in Execute. The fetch PC loads `redirectPCE` at the following rising edge.
- **BTB and counter writes:** take effect at the rising edge ending the Execute cycle. A fetch read of the same index in that cycle sees the old contents (read-before-write).
- **Counter transitions:** at most one step per resolved instruction.
- **Reset (asynchronous, `rst_n` = 0):**
  - All `valid`, `ctr`, `target` and `tag` cleared to 0.
  - `branchCount` and `mispredictCount` = 0.
  - So `predTakenF = 0` and `predTargetF = PCF+4`.
  - With `validE = 0`: `redirectE`, `flushD` and `flushE` = 0, and `redirectPCE = PCPlus4E`.
  - Reset asserted mid-update discards the write.
- **`validE = 0`:** no update, no statistics change, no redirect, regardless of other inputs.

## Test plan
- **Reset, then first BEQ miss.** Reset, then BEQ at `PCE` = 0x40, `PCSrcE` = 01, target 0x80, `predTakenE` = 0.
  - Required: `redirectE` = 1, `redirectPCE` = 0x80, `flushD` = `flushE` = 1.
  - Next cycle, `PCF` = 0x40 gives `predTakenF` = 1 and `predTargetF` = 0x80.
- **Counter hysteresis at 0x40.** After allocation (`ctr` = 10), resolve not-taken once.
  - Required: `ctr` = 01, `predTakenF` = 0, and a redirect to 0x44 in that resolution cycle.
  - Then taken twice: `ctr` = 11, and one not-taken leaves `predTakenF` = 1.
- **Correct prediction.** `predTakenE` = 1, `predTargetE` = 0x80, `PCSrcE` = 01, target 0x80.
  - Required: `redirectE` = 0, `branchCount` +1, `mispredictCount` unchanged.
- **JALR target change.** JALR at 0x100, BTB `target` = 0x200, actual target 0x300, predicted taken.
  - Required: `redirectE` = 1, `redirectPCE` = 0x300, and the BTB `target` becomes 0x300.
- **Alias and bubble.** Tag alias with `ENTRIES` = 16: 0x40 and 0x80 share an index; taken at 0x80 overwrites the entry.
  - Required: `PCF` = 0x40 then predicts not-taken.
  - `validE` = 0 with `predTakenE` = 1 gives no redirect and no count change.
- **Async reset mid-run.** Assert `rst_n` low between edges while entries are valid.
  - Required: `predTakenF` drops to 0 immediately, and both counts read 0.
